qpsk_frame_sched: RTL and testbench

Frame scheduler for the QPSK transmit path. Sequences each burst as a 13-symbol Barker preamble, then a payload taken from an internal 10-bit m-sequence or an external symbol stream, then a guard interval. Emits one 2-bit symbol per symbol strobe toward the modulator and tracks frame count and underruns. Runs in the `clk_fs` domain; the symbol rate is derived by an internal divider.

---
 rtl/qpsk_frame_sched_if.sv | 35 +++
 rtl/qpsk_frame_sched.sv | 205 ++++++++++++++++++++
 tb/tb_qpsk_frame_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_frame_sched_if.sv
// qpsk_frame_sched_if
//   Control, payload-handshake and symbol-output bundle of the QPSK frame
//   scheduler.
//   master : frame requester / payload source / symbol sink (drives start, abort,
//            pn_sel, pay_data, pay_valid)
//   slave  : the scheduler itself (drives pay_ready, sym_*, frame_*, busy,
//            frame_cnt, underrun)
interface qpsk_frame_sched_if;
  logic        start;
  logic        abort;
  logic        pn_sel;
  logic [1:0]  pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic [1:0]  sym_out;
  logic        sym_stb;
  logic [1:0]  sym_type;
  logic        frame_start;
  logic        frame_end;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        underrun;

  modport master (
    output start, abort, pn_sel, pay_data, pay_valid,
    input  pay_ready, sym_out, sym_stb, sym_type, frame_start, frame_end,
           busy, frame_cnt, underrun
  );

  modport slave (
    input  start, abort, pn_sel, pay_data, pay_valid,
    output pay_ready, sym_out, sym_stb, sym_type, frame_start, frame_end,
           busy, frame_cnt, underrun
  );
endinterface

// File: rtl/qpsk_frame_sched.sv
// qpsk_frame_sched
//   Frame scheduler for the QPSK transmit path. Each burst is a 13-symbol
//   Barker preamble, PAYLOAD_LEN payload symbols (internal 10-bit m-sequence
//   or external stream) and GUARD_LEN guard symbols. One 2-bit symbol is
//   emitted per symbol tick; ticks come from an internal divider of clk_fs.
//
// Parameters
//   SYM_DIV     : clk_fs cycles per symbol (>=1)
//   PAYLOAD_LEN : payload symbols per frame (1..4095)
//   GUARD_LEN   : guard symbols per frame (0..255, 0 skips the guard)
//
// Ports
//   clk_fs : sole clock
//   rst    : asynchronous active-high reset
//   bus    : qpsk_frame_sched_if.slave (start/abort/pn_sel, pay_* handshake,
//            sym_out/sym_stb/sym_type, frame_start/frame_end, busy,
//            frame_cnt, underrun). All outputs are registered.
//
// Build option
//   QPSK_FRAME_CONTINUOUS_EN : when defined, frames repeat back-to-back with
//   evenly spaced strobes until abort or rst. Undefined (default): the FSM
//   returns to IDLE after each frame and waits for start.
module qpsk_frame_sched #(
  parameter int SYM_DIV     = 2,
  parameter int PAYLOAD_LEN = 1024,
  parameter int GUARD_LEN   = 8
) (
  input  logic                 clk_fs,
  input  logic                 rst,
  qpsk_frame_sched_if.slave    bus
);

  localparam int                DIV_W      = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SYM_DIV - 1);
  localparam logic [11:0]       PRE_LAST   = 12'd12;
  localparam logic [11:0]       PAY_LAST   = 12'(PAYLOAD_LEN - 1);
  localparam logic [11:0]       GUARD_LAST = 12'(GUARD_LEN - 1);
  localparam logic [9:0]        LFSR_SEED  = 10'b0000000001;

  typedef enum logic [1:0] {IDLE, PRE, PAY, GUARD} state_t;

  // Barker-13 (+ + + + + - - + + - + - +), +1 -> 11, -1 -> 01
  function automatic logic [1:0] barker_sym(input logic [3:0] idx);
    logic [1:0] s;
    case (idx)
      4'd5, 4'd6, 4'd9, 4'd11: s = 2'b01;
      default:                 s = 2'b11;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] lfsr_step(input logic [9:0] l);
    return {l[7] ^ l[0], l[9:1]};
  endfunction

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [11:0]        cnt_q, cnt_n;
  logic [9:0]         lfsr_q, lfsr_n;
  logic               pn_q, pn_n;
  logic               tick_p0;
  logic               frame_done;

  logic [1:0]         sym_n;
  logic [1:0]         type_n;
  logic               stb_n, fs_n, fe_n, busy_n, rdy_n, und_n;
  logic [15:0]        fcnt_n;

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    div_n      = div_q;
    cnt_n      = cnt_q;
    lfsr_n     = lfsr_q;
    pn_n       = pn_q;
    und_n      = bus.underrun;
    fcnt_n     = bus.frame_cnt;
    sym_n      = bus.sym_out;
    type_n     = bus.sym_type;
    stb_n      = 1'b0;
    fs_n       = 1'b0;
    fe_n       = 1'b0;
    frame_done = 1'b0;
    tick_p0    = (state != IDLE) && (div_q == '0);

    if (bus.abort) begin
      // Abort beats everything, including a tick or a start in IDLE.
      state_n = IDLE;
      sym_n   = 2'b00;
      type_n  = 2'd0;
    end else if (state == IDLE) begin
      sym_n  = 2'b00;
      type_n = 2'd0;
      if (bus.start) begin
        state_n = PRE;
        div_n   = '0;
        cnt_n   = '0;
        lfsr_n  = LFSR_SEED;
        pn_n    = bus.pn_sel;
        if (!bus.pn_sel) und_n = 1'b0;
      end
    end else begin
      div_n = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (tick_p0) begin
        stb_n = 1'b1;
        cnt_n = cnt_q + 12'd1;
        case (state)
          PRE: begin
            sym_n  = barker_sym(cnt_q[3:0]);
            type_n = 2'd1;
            fs_n   = (cnt_q == '0);
            if (cnt_q == PRE_LAST) begin
              cnt_n   = '0;
              state_n = PAY;
            end
          end
          PAY: begin
            type_n = 2'd2;
            if (pn_q) begin
              sym_n  = {lfsr_q[0], 1'b1};
              lfsr_n = lfsr_step(lfsr_q);
            end else if (bus.pay_valid) begin
              sym_n = bus.pay_data;
            end else begin
              // Missing external symbol: slot still consumed, frame not stretched.
              sym_n = 2'b00;
              und_n = 1'b1;
            end
            if (cnt_q == PAY_LAST) begin
              cnt_n = '0;
              if (GUARD_LEN == 0) frame_done = 1'b1;
              else                state_n    = GUARD;
            end
          end
          GUARD: begin
            type_n = 2'd3;
            sym_n  = 2'b00;
            if (cnt_q == GUARD_LAST) frame_done = 1'b1;
          end
          default: ;
        endcase

        if (frame_done) begin
          fe_n   = 1'b1;
          fcnt_n = bus.frame_cnt + 16'd1;
          cnt_n  = '0;
`ifdef QPSK_FRAME_CONTINUOUS_EN
          // Behaves like a start accepted on this cycle, except the divider
          // keeps running so the symbol spacing is unbroken.
          state_n = PRE;
          lfsr_n  = LFSR_SEED;
          pn_n    = bus.pn_sel;
          if (!bus.pn_sel) und_n = 1'b0;
`else
          state_n = IDLE;
`endif
        end
      end
    end

    // busy rises together with the first strobe, one cycle after acceptance.
    busy_n = (state != IDLE) && (state_n != IDLE);
    // pay_ready is registered, so it is predicted one cycle ahead of the
    // payload tick on which the external symbol is taken.
    rdy_n  = (state_n == PAY) && !pn_n && (div_n == '0);
  end

  // Stage p1: registered datapath and outputs
  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      div_q           <= '0;
      cnt_q           <= '0;
      lfsr_q          <= LFSR_SEED;
      pn_q            <= 1'b0;
      bus.sym_out     <= 2'b00;
      bus.sym_stb     <= 1'b0;
      bus.sym_type    <= 2'd0;
      bus.pay_ready   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_end   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_cnt   <= 16'd0;
      bus.underrun    <= 1'b0;
    end else begin
      div_q           <= div_n;
      cnt_q           <= cnt_n;
      lfsr_q          <= lfsr_n;
      pn_q            <= pn_n;
      bus.sym_out     <= sym_n;
      bus.sym_stb     <= stb_n;
      bus.sym_type    <= type_n;
      bus.pay_ready   <= rdy_n;
      bus.frame_start <= fs_n;
      bus.frame_end   <= fe_n;
      bus.busy        <= busy_n;
      bus.frame_cnt   <= fcnt_n;
      bus.underrun    <= und_n;
    end
  end

endmodule

// File: tb/tb_qpsk_frame_sched.sv
// tb_qpsk_frame_sched
//   Directed bench for qpsk_frame_sched with SYM_DIV=2, PAYLOAD_LEN=4 and
//   GUARD_LEN=2 (GUARD_LEN=0 when QPSK_FRAME_CONTINUOUS_EN is defined).
//   Outputs are sampled 1 time unit after each rising clk_fs edge.
module tb_qpsk_frame_sched;

  localparam int SD = 2;
  localparam int PL = 4;
`ifdef QPSK_FRAME_CONTINUOUS_EN
  localparam int GL = 0;
`else
  localparam int GL = 2;
`endif
  localparam int NSTB = 13 + PL + GL;

  logic clk_fs = 1'b0;
  logic rst    = 1'b1;

  qpsk_frame_sched_if bus();

  qpsk_frame_sched #(
    .SYM_DIV     (SD),
    .PAYLOAD_LEN (PL),
    .GUARD_LEN   (GL)
  ) dut (
    .clk_fs (clk_fs),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_fs = ~clk_fs;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] exp_fcnt = 16'd0;
  logic        exp_und  = 1'b0;
  logic [1:0]  pre_tab [13];

  task automatic step();
    @(posedge clk_fs);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_sym(input int fi, input logic [7:0] pexp);
    logic [1:0] s;
    if (fi < 13)      s = pre_tab[fi];
    else if (fi < 17) s = pexp[2*(fi-13) +: 2];
    else              s = 2'b00;
    return s;
  endfunction

  function automatic logic [1:0] exp_type(input int fi);
    logic [1:0] t;
    if (fi < 13)      t = 2'd1;
    else if (fi < 17) t = 2'd2;
    else              t = 2'd3;
    return t;
  endfunction

  // One non-continuous frame, checked cycle by cycle. Start is accepted on
  // the first edge; strobe i appears after edge 1+2i. Returns right after
  // the frame_end edge (or one cycle after an abort).
  task automatic frame(input logic pn, input logic [7:0] pdat, input logic [3:0] pvld,
                       input logic [7:0] pexp, input int abort_idx, input int busy_start_c);
    int i;
    int c_last;
    c_last = 2 * NSTB - 1;
    bus.pn_sel = pn;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    if (!pn) exp_und = 1'b0;
    chk("accept_stb", bus.sym_stb, 1'b0);
    chk("accept_busy", bus.busy, 1'b0);
    chk("accept_underrun", bus.underrun, exp_und);
    for (int c = 1; c <= c_last; c++) begin
      i = (c - 1) / 2;
      if ((c % 2 == 1) && i >= 13 && i < 17) begin
        chk($sformatf("pay_ready_s%0d", i), bus.pay_ready, !pn);
        bus.pay_data  = pdat[2*(i-13) +: 2];
        bus.pay_valid = pvld[i-13];
      end else begin
        chk($sformatf("pay_ready_idle_c%0d", c), bus.pay_ready, 1'b0);
        bus.pay_data  = 2'b01;
        bus.pay_valid = 1'b0;
      end
      if (c == busy_start_c) bus.start = 1'b1;
      if (abort_idx >= 0 && c == 2 + 2 * abort_idx) begin
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_stb", bus.sym_stb, 1'b0);
        chk("abort_sym", bus.sym_out, 2'b00);
        chk("abort_frame_end", bus.frame_end, 1'b0);
        chk("abort_frame_cnt", bus.frame_cnt, exp_fcnt);
        step();
        chk("abort_after_busy", bus.busy, 1'b0);
        chk("abort_after_stb", bus.sym_stb, 1'b0);
        return;
      end
      step();
      bus.start = 1'b0;
      chk($sformatf("stb_c%0d", c), bus.sym_stb, (c % 2 == 1));
      chk($sformatf("busy_c%0d", c), bus.busy, (c != c_last));
      if (c % 2 == 1) begin
        if (i >= 13 && i < 17 && !pn && !pvld[i-13]) exp_und = 1'b1;
        chk($sformatf("sym_s%0d", i), bus.sym_out, exp_sym(i, pexp));
        chk($sformatf("type_s%0d", i), bus.sym_type, exp_type(i));
        chk($sformatf("frame_start_s%0d", i), bus.frame_start, (i == 0));
        chk($sformatf("frame_end_s%0d", i), bus.frame_end, (i == NSTB - 1));
      end
      if (c == c_last) exp_fcnt = exp_fcnt + 16'd1;
      chk($sformatf("frame_cnt_c%0d", c), bus.frame_cnt, exp_fcnt);
      chk($sformatf("underrun_c%0d", c), bus.underrun, exp_und);
    end
  endtask

  task automatic idle_check(input string tag);
    step();
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_stb"}, bus.sym_stb, 1'b0);
    chk({tag, "_sym"}, bus.sym_out, 2'b00);
    chk({tag, "_type"}, bus.sym_type, 2'd0);
    chk({tag, "_underrun"}, bus.underrun, exp_und);
  endtask

  initial begin
    int i;
    pre_tab = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01,
                2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.pn_sel    = 1'b1;
    bus.pay_data  = 2'b00;
    bus.pay_valid = 1'b0;

    step();
    step();
    chk("rst_sym_out", bus.sym_out, 2'b00);
    chk("rst_sym_stb", bus.sym_stb, 1'b0);
    chk("rst_sym_type", bus.sym_type, 2'd0);
    chk("rst_pay_ready", bus.pay_ready, 1'b0);
    chk("rst_frame_start", bus.frame_start, 1'b0);
    chk("rst_frame_end", bus.frame_end, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_frame_cnt", bus.frame_cnt, 16'd0);
    chk("rst_underrun", bus.underrun, 1'b0);
    rst = 1'b0;
    step();

`ifdef QPSK_FRAME_CONTINUOUS_EN
    // Two back-to-back frames; payload restarts from the LFSR seed.
    bus.pn_sel = 1'b1;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 4 * NSTB - 1; c++) begin
      step();
      i = (c - 1) / 2;
      chk($sformatf("cont_stb_c%0d", c), bus.sym_stb, (c % 2 == 1));
      chk($sformatf("cont_busy_c%0d", c), bus.busy, 1'b1);
      if (c % 2 == 1) begin
        chk($sformatf("cont_sym_s%0d", i), bus.sym_out, exp_sym(i % NSTB, 8'b01_01_01_11));
        chk($sformatf("cont_fs_s%0d", i), bus.frame_start, (i % NSTB == 0));
        chk($sformatf("cont_fe_s%0d", i), bus.frame_end, (i % NSTB == NSTB - 1));
        if (i % NSTB == NSTB - 1) exp_fcnt = exp_fcnt + 16'd1;
      end
      chk($sformatf("cont_fcnt_c%0d", c), bus.frame_cnt, exp_fcnt);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("cont_abort_busy", bus.busy, 1'b0);
    chk("cont_abort_fcnt", bus.frame_cnt, 16'd2);
    idle_check("cont_idle");
`else
    // Internal m-sequence payload: 11,01,01,01.
    frame(1'b1, 8'h00, 4'b0000, 8'b01_01_01_11, -1, -1);
    idle_check("idle_a");
    chk("idle_a_fcnt", bus.frame_cnt, 16'd1);

    // External payload 00,01,10,11 all valid; a start mid-frame is ignored.
    frame(1'b0, 8'b11_10_01_00, 4'b1111, 8'b11_10_01_00, -1, 10);
    idle_check("idle_b");

    // Second external symbol missing -> 00 and sticky underrun.
    frame(1'b0, 8'b11_10_01_00, 4'b1101, 8'b11_10_00_00, -1, -1);
    idle_check("idle_c1");
    idle_check("idle_c2");

    // start and abort together in IDLE: nothing happens.
    bus.pn_sel = 1'b0;
    bus.start  = 1'b1;
    bus.abort  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 1'b0);
    idle_check("start_abort_1");
    idle_check("start_abort_2");

    // Abort on the 7th preamble strobe, then a complete frame follows.
    frame(1'b1, 8'h00, 4'b0000, 8'b01_01_01_11, 6, -1);
    chk("abort_underrun_kept", bus.underrun, 1'b1);
    frame(1'b0, 8'b00_11_10_01, 4'b1111, 8'b00_11_10_01, -1, -1);
    // Earliest restart: start presented in the frame_end cycle.
    frame(1'b1, 8'h00, 4'b0000, 8'b01_01_01_11, -1, -1);
    idle_check("idle_e");
    chk("idle_e_fcnt", bus.frame_cnt, 16'd5);

    // Asynchronous reset mid-frame.
    bus.pn_sel = 1'b0;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_fcnt", bus.frame_cnt, 16'd0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_stb", bus.sym_stb, 1'b0);
    chk("rst_mid_type", bus.sym_type, 2'd0);
    step();
    rst = 1'b0;
    exp_fcnt = 16'd0;
    exp_und  = 1'b0;
    idle_check("post_rst");
    frame(1'b1, 8'h00, 4'b0000, 8'b01_01_01_11, -1, -1);
    chk("post_rst_fcnt", bus.frame_cnt, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
